// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback controller for the 4-bit combinational alu
//
// Purpose:
//   Holds a small register file and accepts one instruction at a time on a
//   valid/ready input channel.
//   - LOAD writes an immediate value into a register.
//   - An ALU op drives the external alu from the register file for one EXEC
//     cycle, then writes R back and captures CF into a sticky carry bit.
//   Each completed instruction is reported on a valid/ready output channel.
//
// Optional feature (macro ALU_ISSUE_ZERO_FLAG_EN):
//   Adds a registered zf output. zf is set on every register write when the
//   written value is zero.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           instruction handshake
//   in_kind                     0 = ALU op, 1 = LOAD immediate
//   in_op, in_rd, in_rs1,
//   in_rs2, in_imm              instruction fields
//   alu_a, alu_b, alu_op        to the alu (zero outside EXEC)
//   alu_r, alu_cf               from the alu
//   out_valid/out_ready         completion handshake
//   out_rd, out_result          completion record
//   cf                          sticky carry register
//   dbg_sel, dbg_data           combinational register-file read
//   zf                          zero flag (only with ALU_ISSUE_ZERO_FLAG_EN)

module alu_issue_ctrl #(
    parameter int DATA_W  = 4,
    parameter int REG_CNT = 4,
    parameter int ADDR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_cf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_result,
    output logic              cf,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic              zf,
`endif
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] regs [REG_CNT];

    // Only the fields needed after the accept edge are kept. LOAD commits
    // its immediate on the accept edge itself, so kind and imm never need
    // to outlive that edge.
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;

    assign dbg_data = regs[dbg_sel];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the state-decoded outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = 2'b00;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = in_kind ? DONE : EXEC;
                end
            end
            EXEC: begin
                alu_a     = regs[rs1_q];
                alu_b     = regs[rs2_q];
                alu_op    = op_q;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: field latch, register file, completion record, flags.
    // An EXEC cycle interrupted by rst never reaches its writeback because
    // the reset branch takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
            op_q       <= 2'b00;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            cf         <= 1'b0;
            out_rd     <= '0;
            out_result <= '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            zf         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= in_op;
                        rd_q  <= in_rd;
                        rs1_q <= in_rs1;
                        rs2_q <= in_rs2;
                        if (in_kind) begin
                            regs[in_rd] <= in_imm;
                            out_rd      <= in_rd;
                            out_result  <= in_imm;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                            zf          <= (in_imm == '0);
`endif
                        end
                    end
                end
                EXEC: begin
                    // Sources were read combinationally this cycle, so an
                    // aliased rd sees the old value on the read side.
                    regs[rd_q] <= alu_r;
                    cf         <= alu_cf;
                    out_rd     <= rd_q;
                    out_result <= alu_r;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                    zf         <= (alu_r == '0);
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl

module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_kind;
    logic [1:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic [3:0] in_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_r;
    logic       alu_cf;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_rd;
    logic [3:0] out_result;
    logic       cf;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic       zf;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the 4-bit alu; OP=00 is ADD with carry-out.
    always_comb begin
        case (alu_op)
            2'b00:   {alu_cf, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   {alu_cf, alu_r} = {1'b0, alu_a} - {1'b0, alu_b};
            2'b10:   {alu_cf, alu_r} = {1'b0, alu_a & alu_b};
            default: {alu_cf, alu_r} = {1'b0, alu_a | alu_b};
        endcase
    end

    alu_issue_ctrl #(
        .DATA_W (4),
        .REG_CNT(4),
        .ADDR_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .alu_cf    (alu_cf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_result(out_result),
        .cf        (cf),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        .zf        (zf),
`endif
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [3:0] expected);
        dbg_sel = idx;
        #1;
        check(tag, {4'h0, dbg_data}, {4'h0, expected});
    endtask

    // LOAD: accepted on one edge, completion visible right after it.
    task automatic do_load(input logic [1:0] rd, input logic [3:0] imm, input bit release_out);
        in_valid = 1'b1;
        in_kind  = 1'b1;
        in_rd    = rd;
        in_imm   = imm;
        tick();
        in_valid = 1'b0;
        check("load_out_valid", {7'h0, out_valid}, 8'h01);
        check("load_out_rd", {6'h0, out_rd}, {6'h0, rd});
        check("load_out_result", {4'h0, out_result}, {4'h0, imm});
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    // ALU op: EXEC cycle after the accept edge, completion after the next.
    task automatic do_alu(input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [3:0] exp_a, input logic [3:0] exp_b,
                          input logic [3:0] exp_r, input logic exp_cf);
        in_valid = 1'b1;
        in_kind  = 1'b0;
        in_op    = 2'b00;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        tick();
        in_valid = 1'b0;
        check("exec_out_valid", {7'h0, out_valid}, 8'h00);
        check("exec_in_ready", {7'h0, in_ready}, 8'h00);
        check("exec_alu_a", {4'h0, alu_a}, {4'h0, exp_a});
        check("exec_alu_b", {4'h0, alu_b}, {4'h0, exp_b});
        tick();
        check("alu_out_valid", {7'h0, out_valid}, 8'h01);
        check("alu_out_rd", {6'h0, out_rd}, {6'h0, rd});
        check("alu_out_result", {4'h0, out_result}, {4'h0, exp_r});
        check("alu_cf", {7'h0, cf}, {7'h0, exp_cf});
        check("done_alu_a", {4'h0, alu_a}, 8'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_kind   = 1'b0;
        in_op     = 2'b00;
        in_rd     = 2'd0;
        in_rs1    = 2'd0;
        in_rs2    = 2'd0;
        in_imm    = 4'h0;
        out_ready = 1'b0;
        dbg_sel   = 2'd0;
        tick();
        rst = 1'b0;

        // 1. Arbitrary activity, then reset for 2 cycles
        do_load(2'd1, 4'h5, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {7'h0, in_ready}, 8'h01);
        check("rst_out_valid", {7'h0, out_valid}, 8'h00);
        check("rst_cf", {7'h0, cf}, 8'h00);
        check("rst_alu_a", {4'h0, alu_a}, 8'h00);
        check("rst_alu_b", {4'h0, alu_b}, 8'h00);
        check("rst_alu_op", {6'h0, alu_op}, 8'h00);
        check("rst_out_rd", {6'h0, out_rd}, 8'h00);
        check("rst_out_result", {4'h0, out_result}, 8'h00);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("rst_zf", {7'h0, zf}, 8'h00);
`endif
        for (int i = 0; i < 4; i++) begin
            check_reg("rst_reg", i[1:0], 4'h0);
        end

        // 2. Add without carry: 0100 + 0011 = 0111
        do_load(2'd1, 4'b0100, 1'b1);
        do_load(2'd2, 4'b0011, 1'b1);
        do_alu(2'd0, 2'd1, 2'd2, 4'b0100, 4'b0011, 4'b0111, 1'b0);
        check_reg("add_r0", 2'd0, 4'b0111);
        check("idle_in_ready", {7'h0, in_ready}, 8'h01);

        // 3. Add with carry, fully aliased: 1111 + 1111 = 1_1110
        do_load(2'd3, 4'b1111, 1'b1);
        do_alu(2'd3, 2'd3, 2'd3, 4'b1111, 4'b1111, 4'b1110, 1'b1);
        check_reg("carry_r3", 2'd3, 4'b1110);

        // LOAD leaves the sticky carry alone; completion is then held
        do_load(2'd0, 4'b0001, 1'b0);
        check("load_keeps_cf", {7'h0, cf}, 8'h01);

        // 4. Backpressure for 5 cycles with a LOAD r2=1001 presented
        in_valid = 1'b1;
        in_kind  = 1'b1;
        in_rd    = 2'd2;
        in_imm   = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", {7'h0, out_valid}, 8'h01);
            check("bp_out_result", {4'h0, out_result}, 8'h01);
            check("bp_out_rd", {6'h0, out_rd}, 8'h00);
            check("bp_in_ready", {7'h0, in_ready}, 8'h00);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_released", {7'h0, out_valid}, 8'h00);
        check_reg("bp_r2_unchanged", 2'd2, 4'b0011);

        // 5. Reset during EXEC of ALU op rd=2
        in_valid = 1'b1;
        in_kind  = 1'b0;
        in_op    = 2'b00;
        in_rd    = 2'd2;
        in_rs1   = 2'd3;
        in_rs2   = 2'd3;
        tick();
        in_valid = 1'b0;
        check("midop_in_exec", {7'h0, in_ready}, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop_out_valid", {7'h0, out_valid}, 8'h00);
        check("midop_cf", {7'h0, cf}, 8'h00);
        check("midop_in_ready", {7'h0, in_ready}, 8'h01);
        check_reg("midop_r2", 2'd2, 4'h0);
        tick();
        check("midop_no_late_valid", {7'h0, out_valid}, 8'h00);

        // 6. Zero result path: 1000 + 1000 = 1_0000
        do_load(2'd0, 4'b0000, 1'b1);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("zf_load_zero", {7'h0, zf}, 8'h01);
`endif
        do_load(2'd0, 4'b0101, 1'b1);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("zf_load_nonzero", {7'h0, zf}, 8'h00);
`endif
        do_load(2'd1, 4'b1000, 1'b1);
        do_load(2'd2, 4'b1000, 1'b1);
        do_alu(2'd3, 2'd1, 2'd2, 4'b1000, 4'b1000, 4'b0000, 1'b1);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        check("zf_add_zero", {7'h0, zf}, 8'h01);
`endif
        check_reg("zero_r3", 2'd3, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
